uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive-side counterpart to the buffered UART transmit path. Samples the asynchronous RX line, deframes 8N1 characters (LSB first) and pushes each good byte into an internal show-ahead FIFO. Downstream logic drains the FIFO with a read_en/empty handshake. Sticky error flags report framing errors and overruns.

Parameters:
CLOCK_FREQ, 100_000_000, clk frequency in Hz
BAUD_RATE, 115_200, line rate in bits/s; CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE (integer divide, must be >= 4)
DEPTH, 16, FIFO entries; power of two, >= 2

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (asserted at 0)
rx  input  1  serial line, idle high, asynchronous to clk
read_en  input  1  pop head of FIFO this cycle; ignored when empty
read_data  output  8  FIFO head byte, valid whenever empty=0
empty  output  1  FIFO holds no bytes
full  output  1  FIFO holds DEPTH bytes
count  output  $clog2(DEPTH)+1  current occupancy
frame_err  output  1  sticky: stop bit sampled low
overrun  output  1  sticky: good byte arrived while FIFO full
clr_err  input  1  synchronous clear of frame_err and overrun

Behaviour:
- Reset (reset=0, async): FSM=IDLE, counters 0, FIFO pointers 0, empty=1, full=0, count=0, frame_err=0, overrun=0, read_data=0, synchronizer flops=1.
- rx passes through a 2-flop synchronizer; all logic below uses the synchronized value rx_s.
- FSM states IDLE, START, DATA, STOP, WAIT_IDLE; one baud counter (0..CLKS_PER_BIT-1), one 3-bit bit index.
- IDLE: rx_s=0 -> START, counter cleared.
- START: when counter reaches CLKS_PER_BIT/2-1 (mid start bit): rx_s=0 -> DATA, counter cleared, index 0; rx_s=1 -> IDLE (glitch rejected, no flags).
- DATA: every CLKS_PER_BIT cycles sample rx_s into shift register bit [index], LSB first; after index 7 sampled -> STOP.
- STOP: after CLKS_PER_BIT cycles sample rx_s. 1: byte good, push request -> IDLE. 0: byte discarded, frame_err<=1 -> WAIT_IDLE.
- WAIT_IDLE: stay until rx_s=1, then IDLE (prevents break condition from being read as repeated characters).
- Push: byte written the cycle after the stop-bit sample; empty deasserts and count increments the following edge. If full and read_en=0 in the push cycle: byte dropped, overrun<=1, FIFO contents untouched. If full and read_en=1 same cycle: pop and push both succeed, count stays DEPTH.
- Pop: read_en=1 with empty=0 advances read pointer; read_data shows the next entry the following cycle. read_en with empty=1 is a no-op (no pointer move, no error). Simultaneous push and pop with count>0: count unchanged.
- Pointers wrap modulo DEPTH; full/empty from count (or extra pointer MSB), never aliasing.
- clr_err=1 clears both sticky flags at the next edge; a new error set event in the same cycle wins (flag stays 1).
- Reset asserted mid-character: everything returns to reset values immediately; partial byte lost; after release the receiver waits for a fresh falling edge (a line already low at release is a start only after being seen high first: synchronizer resets to 1, so a held-low line starts a frame which then fails STOP -> frame_err, accepted behaviour).
- No combinational path from rx to any output.

Test Plan:
CLOCK_FREQ=16, BAUD_RATE=1 (CLKS_PER_BIT=16) for all scenarios.
- Send 0x48, 0x65, 0x0D back-to-back, no reads -> count=3, read_data=0x48; three pops yield 0x48, 0x65, 0x0D, then empty=1, no flags.
- 5-cycle low pulse on idle rx -> no byte pushed, FSM back in IDLE, frame_err=0.
- Send 0xA5 with stop bit driven low, then rx high -> nothing pushed, frame_err=1; clr_err pulse -> frame_err=0; next 0x3C received normally.
- Send DEPTH+1 bytes 0x00..0x10 with no reads -> full=1, count=16, overrun=1, FIFO holds 0x00..0x0F in order.
- With FIFO full, hold read_en=1 across the next stop-bit push -> count stays 16, overrun=0, new byte appears last in order.
- Assert reset during DATA bit 4 of 0xFF, release, send 0x81 -> only 0x81 in FIFO, count=1.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a show-ahead FIFO, with sticky framing and overrun flags.
// The line is resynchronised and sampled at mid-bit. Every good byte is queued for a read_en/empty consumer.
module uart_rx_fifo #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DEPTH      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rx,
    input  logic                     read_en,
    output logic [7:0]               read_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     frame_err,
    output logic                     overrun,
    input  logic                     clr_err
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int PTR_W        = $clog2(DEPTH);

    localparam logic [CNT_W-1:0] BIT_END    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END   = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    logic             rx_meta_reg;
    logic             rx_s_reg;

    state_t           state_reg;
    logic [CNT_W-1:0] baud_cnt_reg;
    logic [2:0]       bit_idx_reg;
    logic [7:0]       shift_reg;
    logic             push_req_reg;
    logic             frame_err_reg;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic [7:0]       read_data_reg;
    logic             overrun_reg;

    logic             do_pop;
    logic             do_push;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [PTR_W:0]   count_next;
    logic [7:0]       head_next;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= S_IDLE;
            baud_cnt_reg  <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
            push_req_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            push_req_reg <= 1'b0;
            if (clr_err) begin
                frame_err_reg <= 1'b0;
            end
            case (state_reg)
                S_IDLE: begin
                    if (!rx_s_reg) begin
                        state_reg    <= S_START;
                        baud_cnt_reg <= '0;
                    end
                end
                S_START: begin
                    if (baud_cnt_reg == HALF_END) begin
                        baud_cnt_reg <= '0;
                        if (!rx_s_reg) begin
                            state_reg   <= S_DATA;
                            bit_idx_reg <= '0;
                        end else begin
                            state_reg <= S_IDLE;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (baud_cnt_reg == BIT_END) begin
                        baud_cnt_reg           <= '0;
                        shift_reg[bit_idx_reg] <= rx_s_reg;
                        bit_idx_reg            <= bit_idx_reg + 3'd1;
                        if (bit_idx_reg == 3'd7) begin
                            state_reg <= S_STOP;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (baud_cnt_reg == BIT_END) begin
                        baud_cnt_reg <= '0;
                        if (rx_s_reg) begin
                            push_req_reg <= 1'b1;
                            state_reg    <= S_IDLE;
                        end else begin
                            // Setting overrides a same-cycle clr_err.
                            frame_err_reg <= 1'b1;
                            state_reg     <= S_WAIT_IDLE;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + CNT_W'(1);
                    end
                end
                S_WAIT_IDLE: begin
                    if (rx_s_reg) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // A push into a full FIFO is only allowed when a pop frees the slot in the same cycle.
    // shift_reg holds the received byte until the next frame reaches DATA, so it feeds the write port directly.
    always_comb begin
        do_pop      = read_en && (count_reg != '0);
        do_push     = push_req_reg && ((count_reg != FULL_COUNT) || do_pop);
        rd_ptr_next = rd_ptr_reg + PTR_W'(do_pop);
        count_next  = count_reg + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
        head_next   = mem[rd_ptr_next];
        if (do_push && (wr_ptr_reg == rd_ptr_next)) begin
            head_next = shift_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= shift_reg;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            read_data_reg <= '0;
            overrun_reg   <= 1'b0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            // read_data holds its last value while the FIFO is empty.
            if (count_next != '0) begin
                read_data_reg <= head_next;
            end
            if (clr_err) begin
                overrun_reg <= 1'b0;
            end
            if (push_req_reg && (count_reg == FULL_COUNT) && !read_en) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    assign read_data = read_data_reg;
    assign count     = count_reg;
    assign empty     = (count_reg == '0);
    assign full      = (count_reg == FULL_COUNT);
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized self-checking bench for uart_rx_fifo.
// The reference model is a byte queue plus two sticky flags, updated once for each whole frame.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int CPB   = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic       read_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] read_data;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       frame_err;
    logic       overrun;

    int errors = 0;
    int checks = 0;

    byte unsigned model_q[$];
    bit           m_frame_err = 1'b0;
    bit           m_overrun = 1'b0;

    uart_rx_fifo #(
        .CLOCK_FREQ(16),
        .BAUD_RATE (1),
        .DEPTH     (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .read_en  (read_en),
        .read_data(read_data),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .frame_err(frame_err),
        .overrun  (overrun),
        .clr_err  (clr_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check_val({tag, ".count"}, 32'(count), model_q.size());
        check_val({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
        check_val({tag, ".full"}, 32'(full), 32'(model_q.size() == DEPTH));
        check_val({tag, ".frame_err"}, 32'(frame_err), 32'(m_frame_err));
        check_val({tag, ".overrun"}, 32'(overrun), 32'(m_overrun));
        if (model_q.size() > 0) begin
            check_val({tag, ".read_data"}, 32'(read_data), 32'(model_q[0]));
        end
        $display("%s: count=%0d head=%02h frame_err=%0b overrun=%0b",
                 tag, count, read_data, frame_err, overrun);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One whole frame, 16 clocks per bit. Optional read_en lands on the push cycle and optional clr_err on the stop-sample cycle.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input bit pop_at_push, input bit clr_at_stop);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int c = 0; c < 10 * CPB; c++) begin
            rx      = frame[c / CPB];
            read_en = pop_at_push && (c == 155);
            clr_err = clr_at_stop && (c == 154);
            tick(1);
        end
        rx      = 1'b1;
        read_en = 1'b0;
        clr_err = 1'b0;
        tick(4);
        if (clr_at_stop) begin
            m_frame_err = 1'b0;
            m_overrun   = 1'b0;
        end
        if (pop_at_push && model_q.size() > 0) begin
            void'(model_q.pop_front());
        end
        if (!stop_bit) begin
            m_frame_err = 1'b1;
        end else if (model_q.size() < DEPTH) begin
            model_q.push_back(b);
        end else begin
            m_overrun = 1'b1;
        end
    endtask

    task automatic pop_byte(input string tag);
        read_en = 1'b1;
        tick(1);
        read_en = 1'b0;
        if (model_q.size() > 0) begin
            void'(model_q.pop_front());
        end
        check_state(tag);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        m_frame_err = 1'b0;
        m_overrun   = 1'b0;
    endtask

    initial begin
        logic [7:0] rb;
        bit         rstop, rpop, rclr;
        int         npop;

        tick(3);
        check_state("reset_held");
        check_val("reset_held.read_data", 32'(read_data), 32'h0);
        reset = 1'b1;
        tick(2);
        check_state("reset_released");

        // Three back-to-back bytes, then drain the FIFO and try one extra read while it is empty.
        send_frame(8'h48, 1'b1, 1'b0, 1'b0);
        send_frame(8'h65, 1'b1, 1'b0, 1'b0);
        send_frame(8'h0D, 1'b1, 1'b0, 1'b0);
        check_state("three_bytes");
        check_val("three_bytes.count3", 32'(count), 32'd3);
        check_val("three_bytes.head", 32'(read_data), 32'h48);
        pop_byte("pop1");
        pop_byte("pop2");
        pop_byte("pop3");
        pop_byte("pop_empty");

        // A short low glitch must be rejected without any flag.
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(40);
        check_state("glitch");

        // A low stop bit sets the framing error. A clear pulse removes it, and the next byte arrives normally.
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        check_state("bad_stop");
        pulse_clr();
        check_state("clr_frame");
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        check_state("after_clr");
        pop_byte("pop_3c");

        // If clr_err coincides with a new framing error, the error is kept.
        send_frame(8'h77, 1'b0, 1'b0, 1'b1);
        check_state("set_wins");
        pulse_clr();

        // Send DEPTH+1 bytes: the last byte overruns.
        for (int i = 0; i <= DEPTH; i++) begin
            send_frame(8'(i), 1'b1, 1'b0, 1'b0);
        end
        check_state("overflow");
        pulse_clr();
        check_state("overflow_clr");

        // While full, a pop in the push cycle lets the new byte in without an overrun.
        send_frame(8'h55, 1'b1, 1'b1, 1'b0);
        check_state("full_pop_push");
        for (int i = 0; i < DEPTH; i++) begin
            pop_byte($sformatf("drain%0d", i));
        end

        // Reset in the middle of DATA bit 4 of 0xFF.
        rx = 1'b0;
        tick(CPB);
        rx = 1'b1;
        tick(4 * CPB + CPB / 2);
        reset = 1'b0;
        #1;
        model_q.delete();
        m_frame_err = 1'b0;
        m_overrun   = 1'b0;
        check_state("mid_reset");
        tick(3);
        reset = 1'b1;
        tick(20);
        send_frame(8'h81, 1'b1, 1'b0, 1'b0);
        check_state("after_reset");
        check_val("after_reset.count1", 32'(count), 32'd1);
        pop_byte("pop_81");

        // Randomized frames, with reads mixed in.
        for (int i = 0; i < 24; i++) begin
            rb    = 8'($urandom_range(0, 255));
            rstop = ($urandom_range(0, 5) != 0);
            rpop  = ($urandom_range(0, 3) == 0);
            rclr  = ($urandom_range(0, 4) == 0);
            send_frame(rb, rstop, rpop, rclr);
            check_state($sformatf("rand%0d_rx%02h", i, rb));
            npop = $urandom_range(0, 2);
            for (int k = 0; k < npop; k++) begin
                pop_byte($sformatf("rand%0d_pop%0d", i, k));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
